bcd_scan_display: RTL and testbench

//  Downstream consumer of the ripple decade counter. Synchronises and de-glitches its Q3..Q0 outputs.

---
 rtl/bcd_disp_pkg.sv | 15 +
 rtl/bcd_seg_decode.sv | 14 +
 rtl/bcd_scan_display.sv | 105 ++++++++++
 tb/tb_bcd_scan_display.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD digit type, 7-segment lookup and BCD increment helper.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Returns {carry_out, next_digit}; a 9 with carry_in wraps to 0 and carries.
    function automatic logic [4:0] bcd_inc(input bcd_t v, input logic cin);
        return !cin ? {1'b0, v} : (v == 4'd9) ? 5'h10 : {1'b0, v + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: BCD digit to active-high {g,f,e,d,c,b,a} segments, with forced blanking.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  bcd_t       bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = (blank || bcd > 4'd9) ? 7'h00 : SEG_LUT[bcd];
    end

endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: de-glitches a ripple decade counter, extends it to NDIG BCD digits and scans them
// onto one 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zero digits above the units.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int STABLE_CYC  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic            clock,
    input  logic            clear_n,
    input  logic [3:0]      q_in,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            overflow
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int IW = $clog2(NDIG);

    logic [3:0]      sync_q, s_q, prev_q;
    logic [SW-1:0]   stab_q, stab_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    bcd_t            dig_q [NDIG];
    bcd_t            dig_d [NDIG];
    logic            ovf_q, ovf_d;
    logic [6:0]      seg_q, seg_d;
    logic [NDIG-1:0] an_q, an_d;
    logic            accept, carry, blank, tick;

    always_comb begin
        stab_d = (s_q != prev_q) ? '0 : (stab_q == SW'(STABLE_CYC)) ? stab_q : stab_q + 1'b1;
        // Out-of-range codes such as the counter's transient 1010 are never accepted.
        accept = (stab_q == SW'(STABLE_CYC)) && (s_q <= 4'd9) && (s_q != dig_q[0]);
        dig_d  = dig_q;
        carry  = 1'b0;
        if (accept) begin
            dig_d[0] = s_q;
            carry    = (dig_q[0] == 4'd9) && (s_q == 4'd0);
        end
        for (int k = 1; k < NDIG; k++) {carry, dig_d[k]} = bcd_inc(dig_q[k], carry);
        ovf_d  = ovf_q | carry;
        tick   = (rcnt_q == RW'(REFRESH_DIV - 1));
        rcnt_d = tick ? '0 : rcnt_q + 1'b1;
        idx_d  = !tick ? idx_q : (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        an_d   = NDIG'(1) << idx_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0] lz;
    logic            z;

    // lz[k] marks digit k and every digit above it as zero; the units digit always shows.
    always_comb begin
        lz = '0;
        z  = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            z     = z & (dig_q[k] == 4'd0);
            lz[k] = z;
        end
        blank = lz[idx_q];
    end
`else
    assign blank = 1'b0;
`endif

    bcd_seg_decode u_dec (
        .bcd   (dig_q[idx_q]),
        .blank (blank),
        .seg   (seg_d)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
            s_q    <= '0;
            prev_q <= '0;
            stab_q <= '0;
            rcnt_q <= '0;
            idx_q  <= '0;
            dig_q  <= '{default: '0};
            ovf_q  <= 1'b0;
            seg_q  <= '0;
            an_q   <= '0;
        end else begin
            sync_q <= q_in;
            s_q    <= sync_q;
            prev_q <= s_q;
            stab_q <= stab_d;
            rcnt_q <= rcnt_d;
            idx_q  <= idx_d;
            dig_q  <= dig_d;
            ovf_q  <= ovf_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench; a 4-digit scan instance and a 2-digit instance for overflow.
module tb_bcd_scan_display;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int RD = 3;

    localparam logic [6:0] LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic [3:0]   q_in = 4'd0;
    logic [6:0]   seg, seg2;
    logic [N-1:0] an;
    logic [1:0]   an2;
    logic         overflow, overflow2;

    int checks = 0;
    int errors = 0;
    int m [N];
    logic [27:0] disp_q [$];
    logic [31:0] an_q [$];

    always #5 clock = ~clock;

    bcd_scan_display #(.NDIG(N), .STABLE_CYC(SC), .REFRESH_DIV(RD)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .q_in     (q_in),
        .seg      (seg),
        .an       (an),
        .overflow (overflow)
    );

    bcd_scan_display #(.NDIG(2), .STABLE_CYC(SC), .REFRESH_DIV(RD)) dut2 (
        .clock    (clock),
        .clear_n  (clear_n),
        .q_in     (q_in),
        .seg      (seg2),
        .an       (an2),
        .overflow (overflow2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int k);
        bit z;
        z = 1'b1;
        for (int j = k; j < N; j++) if (m[j] != 0) z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && z) return 7'h00;
`endif
        return LUT[m[k]];
    endfunction

    function automatic logic [27:0] model_display();
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*7 +: 7] = exp_seg(k);
        return r;
    endfunction

    task automatic model_apply(input int v);
        bit c;
        if (v <= 9 && v != m[0]) begin
            c = (m[0] == 9 && v == 0);
            m[0] = v;
            for (int k = 1; k < N; k++) begin
                if (c) begin
                    if (m[k] == 9) m[k] = 0;
                    else begin
                        m[k]++;
                        c = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive(input int v, input int n);
        q_in = v[3:0];
        repeat (n) @(negedge clock);
        if (n >= 8) model_apply(v);
    endtask

    task automatic wrap();
        for (int v = 1; v <= 9; v++) drive(v, 10);
        drive(0, 10);
    endtask

    task automatic check_display(input string tag);
        logic [27:0] got;
        disp_q.push_back(model_display());
        got = '0;
        repeat (2 * RD * N) begin
            @(negedge clock);
            for (int k = 0; k < N; k++) if (an == N'(1 << k)) got[k*7 +: 7] = seg;
        end
        check(tag, {4'h0, got}, {4'h0, disp_q.pop_front()});
    endtask

    task automatic check_display2(input string tag, input logic [13:0] exp);
        logic [13:0] got;
        got = '0;
        repeat (4 * RD) begin
            @(negedge clock);
            if (an2 == 2'b01) got[6:0] = seg2;
            if (an2 == 2'b10) got[13:7] = seg2;
        end
        check(tag, {18'h0, got}, {18'h0, exp});
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        check("rst_seg", {25'h0, seg}, 32'h0);
        check("rst_an", {28'h0, an}, 32'h0);
        check("rst_ovf", {31'h0, overflow2}, 32'h0);
        @(negedge clock);
        clear_n = 1'b1;
        for (int k = 0; k < N; k++) m[k] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) m[k] = 0;
        repeat (3) @(negedge clock);
        check("rst_init_an", {28'h0, an}, 32'h0);
        clear_n = 1'b1;
        for (int c = 0; c < 5 * RD; c++) begin
            an_q.push_back(32'(1 << ((c / RD) % N)));
            @(posedge clock);
            #1;
            check("scan_an", {28'h0, an}, an_q.pop_front());
            if (c == 0) check("first_seg", {25'h0, seg}, 32'h3F);
        end
        @(negedge clock);
        for (int v = 1; v <= 9; v++) begin
            drive(v, 10);
            check_display("ramp");
        end
        drive(0, 10);
        check_display("ramp_carry");
        drive(9, 10);
        drive(10, 12);
        check_display("reject_1010");
        drive(0, 10);
        check_display("carry_after_hold");
        drive(9, 10);
        drive(10, 2);
        drive(0, 10);
        check_display("transient_1010");
        drive(4, 10);
        drive(7, SC - 1);
        drive(4, 10);
        check_display("glitch");
        drive(7, 10);
        check_display("jump");
        drive(5, 10);
        drive(0, 10);
        check_display("clear_jump");
        do_reset();
        check_display("after_reset");
        repeat (4) wrap();
        drive(1, 10);
        drive(2, 10);
        check_display("value_42");
        do_reset();
        repeat (9) wrap();
        check("ovf_before", {31'h0, overflow2}, 32'h0);
        wrap();
        check("ovf_set", {31'h0, overflow2}, 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
        check_display2("wrap_to_00", {7'h00, 7'h3F});
`else
        check_display2("wrap_to_00", {7'h3F, 7'h3F});
`endif
        check_display("value_100");
        wrap();
        drive(3, 10);
        check("ovf_sticky", {31'h0, overflow2}, 32'h1);
        check_display2("after_ovf", {7'h06, 7'h4F});
        do_reset();
        @(negedge clock);
        check("ovf_cleared", {31'h0, overflow2}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
